// File: rtl/nv_nvdla_sdp_rdma_rd_arb.sv
// SDP read-DMA request arbiter: round-robin over NREQ requesters,
// gated by a shared latency-FIFO credit pool, with a registered output slot.
module nv_nvdla_sdp_rdma_rd_arb #(
  parameter int NREQ      = 4,
  parameter int PD_W      = 79,
  parameter int CDT_DEPTH = 256,
  parameter int CDT_W     = 9
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*PD_W-1:0] req_pd,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [PD_W-1:0]      rd_req_pd,
  output logic [1:0]           rd_req_src,
  input  logic                 rd_cdt_lat_fifo_pop,
  output logic [CDT_W-1:0]     cdt_cnt,
  output logic                 cdt_err,
  output logic                 arb_idle
);

  localparam int SZ_W   = PD_W - 64;
  // wide enough that size+1 never wraps
  localparam int NEED_W = (CDT_W + 6 > SZ_W) ? CDT_W + 6 : SZ_W + 1;
  localparam logic [CDT_W-1:0] FULL = CDT_W'(CDT_DEPTH);

  logic             r_valid;
  logic [PD_W-1:0]  r_pd;
  logic [1:0]       r_src;
  logic [1:0]       r_rr_ptr;
  logic [CDT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_idle;

  logic [2:0]       w_tmp;
  logic [1:0]       w_win;
  logic             w_any;
  logic [PD_W-1:0]  w_win_pd;
  logic [NEED_W-1:0] w_need;
  logic [NEED_W-1:0] w_cnt_ext;
  logic             w_slot_free;
  logic             w_grant;
  logic             w_ovf;
  logic             w_pop_add;
  logic [CDT_W-1:0] w_cnt_nxt;
  logic             w_valid_nxt;
  logic [2:0]       w_win_inc;
  logic [1:0]       w_rr_nxt;

  // first valid requester scanning upward from the rr pointer
  always_comb begin
    w_tmp = 3'd0;
    w_win = r_rr_ptr;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_tmp = {1'b0, r_rr_ptr} + 3'(k);
      if (w_tmp >= 3'(NREQ)) w_tmp = w_tmp - 3'(NREQ);
      if (!w_any && req_valid[w_tmp[1:0]]) begin
        w_any = 1'b1;
        w_win = w_tmp[1:0];
      end
    end
  end

  always_comb begin
    w_win_pd = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_win == 2'(i)) w_win_pd = req_pd[i*PD_W +: PD_W];
  end

  assign w_need      = NEED_W'(w_win_pd[PD_W-1:64]) + NEED_W'(1);
  assign w_cnt_ext   = NEED_W'(r_cnt);
  assign w_slot_free = !r_valid || rd_req_ready;
  assign w_grant     = !nvdla_core_rst && w_slot_free && w_any &&
                       (w_cnt_ext >= w_need);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant && w_win == 2'(i)) req_ready[i] = 1'b1;
  end

  assign w_ovf     = rd_cdt_lat_fifo_pop && !w_grant && (r_cnt == FULL);
  assign w_pop_add = rd_cdt_lat_fifo_pop && !w_ovf;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_grant) w_cnt_nxt = w_cnt_nxt - w_need[CDT_W-1:0];
    if (w_pop_add) w_cnt_nxt = w_cnt_nxt + CDT_W'(1);
  end

  assign w_valid_nxt = w_grant || (r_valid && !rd_req_ready);
  assign w_win_inc   = {1'b0, w_win} + 3'd1;
  assign w_rr_nxt    = (w_win_inc >= 3'(NREQ)) ? 2'd0 : w_win_inc[1:0];

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_valid  <= 1'b0;
      r_pd     <= '0;
      r_src    <= 2'd0;
      r_rr_ptr <= 2'd0;
      r_cnt    <= FULL;
      r_err    <= 1'b0;
      r_idle   <= 1'b1;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_grant) begin
        r_pd     <= w_win_pd;
        r_src    <= w_win;
        r_rr_ptr <= w_rr_nxt;
      end
      r_cnt  <= w_cnt_nxt;
      r_idle <= !w_valid_nxt && (w_cnt_nxt == FULL);
      if (w_ovf) r_err <= 1'b1;
    end
  end

  assign rd_req_valid = r_valid;
  assign rd_req_pd    = r_pd;
  assign rd_req_src   = r_src;
  assign cdt_cnt      = r_cnt;
  assign cdt_err      = r_err;
  assign arb_idle     = r_idle;

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_rd_arb.sv
// Bench for nv_nvdla_sdp_rdma_rd_arb: directed scenario tasks plus a
// payload scoreboard fed at grant time and drained at downstream accept.
module tb_nv_nvdla_sdp_rdma_rd_arb;

  localparam int NREQ = 4;
  localparam int PD_W = 79;
  localparam int CDT_W = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*PD_W-1:0] req_pd = '0;
  logic                 rd_req_valid;
  logic                 rd_req_ready = 1'b0;
  logic [PD_W-1:0]      rd_req_pd;
  logic [1:0]           rd_req_src;
  logic                 pop = 1'b0;
  logic [CDT_W-1:0]     cdt_cnt;
  logic                 cdt_err;
  logic                 arb_idle;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PD_W+1:0] sb[$];

  nv_nvdla_sdp_rdma_rd_arb dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_pd              (req_pd),
    .rd_req_valid        (rd_req_valid),
    .rd_req_ready        (rd_req_ready),
    .rd_req_pd           (rd_req_pd),
    .rd_req_src          (rd_req_src),
    .rd_cdt_lat_fifo_pop (pop),
    .cdt_cnt             (cdt_cnt),
    .cdt_err             (cdt_err),
    .arb_idle            (arb_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [PD_W-1:0] mkpd(input int sz, input logic [63:0] a);
    logic [14:0] s;
    s = 15'(sz);
    return {s, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input int i, input int sz, input logic [63:0] a);
    req_pd[i*PD_W +: PD_W] = mkpd(sz, a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    pop = 1'b0;
    rd_req_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // scoreboard: push at grant, pop/compare at downstream accept
  always @(negedge clk) begin
    logic [PD_W+1:0] e;
    if (rst) sb.delete();
    else begin
      if (rd_req_valid && rd_req_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_empty: got src=%0d pd=%h, none expected",
                   rd_req_src, rd_req_pd);
        end else begin
          e = sb.pop_front();
          if ({rd_req_src, rd_req_pd} !== e) begin
            n_bad++;
            $display("FAIL sb_pd: got src=%0d pd=%h, want src=%0d pd=%h",
                     rd_req_src, rd_req_pd, e[PD_W+1:PD_W], e[PD_W-1:0]);
          end
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && req_valid[i])
          sb.push_back({2'(i), req_pd[i*PD_W +: PD_W]});
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      pop = 1'($urandom_range(0, 1));
      rd_req_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) set_pd(i, 0, 64'($urandom));
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0) begin
        n_bad++;
        $display("FAIL rst_req_ready: got %b want 0000", req_ready);
      end
      cyc();
    end
    rst = 1'b0;
    req_valid = '0;
    pop = 1'b0;
    rd_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rd_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", rd_req_valid);
    end
    n_cmp++;
    if (cdt_cnt !== 9'd256) begin
      n_bad++; $display("FAIL rst_cnt: got %0d want 256", cdt_cnt);
    end
    n_cmp++;
    if (arb_idle !== 1'b1 || cdt_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_idle_err: got idle=%b err=%b want 1 0", arb_idle, cdt_err);
    end
    n_cmp++;
    if (rd_req_src !== 2'd0 || rd_req_pd !== '0) begin
      n_bad++;
      $display("FAIL rst_pd: got src=%0d pd=%h want 0 0", rd_req_src, rd_req_pd);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_pd(1, 0, 64'h1000);
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rd_req_valid !== 1'b1 || rd_req_src !== 2'd1 ||
        rd_req_pd[63:0] !== 64'h1000) begin
      n_bad++;
      $display("FAIL single_out: got v=%b src=%0d addr=%h want 1 1 1000",
               rd_req_valid, rd_req_src, rd_req_pd[63:0]);
    end
    n_cmp++;
    if (cdt_cnt !== 9'd255) begin
      n_bad++; $display("FAIL single_cnt: got %0d want 255", cdt_cnt);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_pd(i, 0, 64'h2000 + 64'(i * 64));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got %b want %b", k, req_ready,
                 4'(1 << (k % 4)));
      end
      n_cmp++;
      if (cdt_cnt !== 9'(256 - k)) begin
        n_bad++;
        $display("FAIL rr_cnt[%0d]: got %0d want %0d", k, cdt_cnt, 256 - k);
      end
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_credit_stall();
    do_reset();
    set_pd(3, 252, 64'h3000);
    req_valid = 4'b1000;
    cyc();
    set_pd(0, 7, 64'h4000);
    set_pd(2, 0, 64'h4200);
    req_valid = 4'b0101;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0 || cdt_cnt !== 9'd3) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got rdy=%b cnt=%0d want 0000 3",
                 j, req_ready, cdt_cnt);
      end
      cyc();
    end
    pop = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0 || cdt_cnt !== 9'(3 + j)) begin
        n_bad++;
        $display("FAIL stall_pop[%0d]: got rdy=%b cnt=%0d want 0000 %0d",
                 j, req_ready, cdt_cnt, 3 + j);
      end
      cyc();
    end
    pop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || cdt_cnt !== 9'd8) begin
      n_bad++;
      $display("FAIL stall_grant: got rdy=%b cnt=%0d want 0001 8",
               req_ready, cdt_cnt);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0 || cdt_cnt !== 9'd0) begin
      n_bad++;
      $display("FAIL stall_after: got rdy=%b cnt=%0d want 0000 0",
               req_ready, cdt_cnt);
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_grant_pop();
    do_reset();
    set_pd(3, 245, 64'h5000);
    req_valid = 4'b1000;
    cyc();
    set_pd(0, 3, 64'h5100);
    req_valid = 4'b0001;
    pop = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || cdt_cnt !== 9'd10) begin
      n_bad++;
      $display("FAIL gp_pre: got rdy=%b cnt=%0d want 0001 10", req_ready, cdt_cnt);
    end
    cyc();
    req_valid = '0;
    pop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cdt_cnt !== 9'd7) begin
      n_bad++; $display("FAIL gp_cnt: got %0d want 7", cdt_cnt);
    end
    do_reset();
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    cyc();
    @(negedge clk);
    n_cmp++;
    if (cdt_cnt !== 9'd256 || cdt_err !== 1'b1 || arb_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf: got cnt=%0d err=%b idle=%b want 256 1 1",
               cdt_cnt, cdt_err, arb_idle);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [PD_W-1:0] p0;
    do_reset();
    p0 = mkpd(0, 64'h6000);
    set_pd(0, 0, 64'h6000);
    set_pd(1, 0, 64'h6100);
    rd_req_ready = 1'b0;
    req_valid = 4'b0011;
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0 || rd_req_valid !== 1'b1 ||
          rd_req_pd !== p0 || rd_req_src !== 2'd0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b src=%0d pd=%h",
                 k, req_ready, rd_req_valid, rd_req_src, rd_req_pd);
      end
      n_cmp++;
      if (cdt_cnt !== 9'd255) begin
        n_bad++; $display("FAIL bp_cnt[%0d]: got %0d want 255", k, cdt_cnt);
      end
      cyc();
    end
    rd_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL bp_rel0: got %b want 0010", req_ready);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || rd_req_src !== 2'd1 || cdt_cnt !== 9'd254) begin
      n_bad++;
      $display("FAIL bp_rel1: got rdy=%b src=%0d cnt=%0d want 0001 1 254",
               req_ready, rd_req_src, cdt_cnt);
    end
    cyc();
    req_valid = '0;
    cyc();
  endtask

  task automatic test_midop_reset();
    do_reset();
    rd_req_ready = 1'b0;
    set_pd(3, 155, 64'h7000);
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (cdt_cnt !== 9'd100 || rd_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got cnt=%0d v=%b want 100 1", cdt_cnt, rd_req_valid);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd_req_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_pd(i, 0, 64'h8000 + 64'(i));
    req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (rd_req_valid !== 1'b0 || cdt_cnt !== 9'd256 || req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_post: got v=%b cnt=%0d rdy=%b want 0 256 0001",
               rd_req_valid, cdt_cnt, req_ready);
    end
    cyc();
    req_valid = '0;
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 150; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rd_req_ready = 1'($urandom_range(0, 3) != 0);
      pop = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++)
        set_pd(i, int'($urandom_range(0, 3)), 64'($urandom));
      @(negedge clk);
      n_cmp++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) !== 4'b0) begin
        n_bad++;
        $display("FAIL rnd_ready[%0d]: got %b valid=%b", c, req_ready, req_valid);
      end
      cyc();
    end
    req_valid = '0;
    rd_req_ready = 1'b1;
    pop = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_grant_pop();
    test_backpressure();
    test_midop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
